// File: rtl/mux2to1_rr_pkg.sv
// Shared constants for the round-robin 2:1 mux arbiter.
// Select encoding follows the mux convention sel ? a : b.
package mux2to1_rr_pkg;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  localparam int unsigned WIDTH_DEFAULT = 8;

endpackage

// File: rtl/mux2to1.sv
// Single-bit 2:1 multiplexer: y = sel ? a : b.
module mux2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? a : b;

endmodule

// File: rtl/mux2to1_vec.sv
// WIDTH-bit 2:1 mux built from one mux2to1 per bit, all sharing one select.
module mux2to1_vec
  import mux2to1_rr_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2to1 u_mux (
      .a   (i_a[i]),
      .b   (i_b[i]),
      .sel (i_sel),
      .y   (o_y[i])
    );
  end

endmodule

// File: rtl/mux2to1_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between two valid/ready requesters,
// with a single-entry output register towards the consumer.
module mux2to1_rr_arbiter
  import mux2to1_rr_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_sel
);

  logic             r_y_valid;
  logic [WIDTH-1:0] r_y_data;
  logic             r_y_sel;
  logic             r_prio;

  logic             w_free;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic             w_gnt_any;
  logic             w_sel;
  logic [WIDTH-1:0] w_mux_data;

  // A draining register counts as free so beats can go back-to-back.
  assign w_free = !r_y_valid || y_ready;

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!rst && w_free) begin
      if (a_valid && b_valid) begin
        w_gnt_a = (r_prio == SEL_A);
        w_gnt_b = (r_prio == SEL_B);
      end else begin
        w_gnt_a = a_valid;
        w_gnt_b = b_valid;
      end
    end
  end

  assign w_gnt_any = w_gnt_a || w_gnt_b;
  assign w_sel     = w_gnt_a ? SEL_A : SEL_B;

  mux2to1_vec #(
    .WIDTH (WIDTH)
  ) u_mux_vec (
    .i_a   (a_data),
    .i_b   (b_data),
    .i_sel (w_sel),
    .o_y   (w_mux_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
      r_y_sel   <= SEL_B;
      r_prio    <= SEL_A;
    end else if (w_gnt_any) begin
      r_y_valid <= 1'b1;
      r_y_data  <= w_mux_data;
      r_y_sel   <= w_sel;
      r_prio    <= !w_sel;
    end else if (y_ready) begin
      // Data and select keep their last values once the beat is taken.
      r_y_valid <= 1'b0;
    end
  end

  assign a_ready = w_gnt_a;
  assign b_ready = w_gnt_b;
  assign y_valid = r_y_valid;
  assign y_data  = r_y_data;
  assign y_sel   = r_y_sel;

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// Scenario-driven bench for mux2to1_rr_arbiter with an expected-beat queue.
module tb_mux2to1_rr_arbiter;

  localparam int unsigned W = 8;

  typedef struct {
    logic         sel;
    logic [W-1:0] data;
  } beat_t;

  logic         clk;
  logic         rst;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b_data;
  logic         y_valid;
  logic         y_ready;
  logic [W-1:0] y_data;
  logic         y_sel;

  beat_t sb[$];
  beat_t exp_b;
  int    total = 0;
  int    bad   = 0;

  mux2to1_rr_arbiter #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_data  (b_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data),
    .y_sel   (y_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 8'hFF;
    b_data  = 8'hEE;
    y_ready = 1'b1;
    tick();
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got a=%b b=%b want a=0 b=0", a_ready, b_ready);
    end
    tick();
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready2: got a=%b b=%b want a=0 b=0", a_ready, b_ready);
    end
    total++;
    if (y_valid !== 1'b0 || y_data !== 8'h00 || y_sel !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%h s=%b want v=0 d=00 s=0", y_valid, y_data, y_sel);
    end
    rst     = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_single();
    a_valid = 1'b1;
    a_data  = 8'h11;
    b_valid = 1'b0;
    y_ready = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_grant: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
    end
    sb.push_back('{sel: 1'b1, data: 8'h11});
    tick();
    a_valid = 1'b0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL single_out: no expected beat queued");
    end else begin
      exp_b = sb.pop_front();
      total++;
      if (y_valid !== 1'b1 || y_data !== exp_b.data || y_sel !== exp_b.sel) begin
        bad++;
        $display("FAIL single_out: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                 y_valid, y_data, y_sel, exp_b.data, exp_b.sel);
      end
    end
    tick();
    total++;
    if (y_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: got v=%b want v=0", y_valid);
    end
  endtask

  task automatic test_alternation();
    int  ia;
    int  ib;
    logic ea;
    pulse_reset();
    ia      = 0;
    ib      = 0;
    y_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_valid = 1'b1;
      b_valid = 1'b1;
      a_data  = 8'hA0 + 8'(ia);
      b_data  = 8'hB0 + 8'(ib);
      #1;
      ea = (k % 2 == 0);
      total++;
      if (a_ready !== ea || b_ready !== !ea) begin
        bad++;
        $display("FAIL alt_grant%0d: got a=%b b=%b want a=%b b=%b", k, a_ready, b_ready, ea, !ea);
      end
      sb.push_back('{sel: ea, data: ea ? a_data : b_data});
      tick();
      if (ea) ia++;
      else    ib++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL alt_out%0d: no expected beat queued", k);
      end else begin
        exp_b = sb.pop_front();
        total++;
        if (y_valid !== 1'b1 || y_data !== exp_b.data || y_sel !== exp_b.sel) begin
          bad++;
          $display("FAIL alt_out%0d: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                   k, y_valid, y_data, y_sel, exp_b.data, exp_b.sel);
        end
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    // Register still holds B1 with y_ready high, so A is accepted immediately.
    a_valid = 1'b1;
    a_data  = 8'h5A;
    b_valid = 1'b0;
    y_ready = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_load: got a_ready=%b want 1", a_ready);
    end
    sb.push_back('{sel: 1'b1, data: 8'h5A});
    tick();
    a_data  = 8'h66;
    b_valid = 1'b1;
    b_data  = 8'h77;
    y_ready = 1'b0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL bp_first: no expected beat queued");
    end else begin
      exp_b = sb.pop_front();
      total++;
      if (y_valid !== 1'b1 || y_data !== exp_b.data || y_sel !== exp_b.sel) begin
        bad++;
        $display("FAIL bp_first: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                 y_valid, y_data, y_sel, exp_b.data, exp_b.sel);
      end
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || y_valid !== 1'b1 ||
          y_data !== 8'h5A || y_sel !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d: got a=%b b=%b v=%b d=%h s=%b want a=0 b=0 v=1 d=5a s=1",
                 k, a_ready, b_ready, y_valid, y_data, y_sel);
      end
      tick();
    end
    y_ready = 1'b1;
    #1;
    // Last grant was A, so B wins the tie.
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got a=%b b=%b want a=0 b=1", a_ready, b_ready);
    end
    sb.push_back('{sel: 1'b0, data: 8'h77});
    tick();
    b_valid = 1'b0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL bp_next: no expected beat queued");
    end else begin
      exp_b = sb.pop_front();
      total++;
      if (y_valid !== 1'b1 || y_data !== exp_b.data || y_sel !== exp_b.sel) begin
        bad++;
        $display("FAIL bp_next: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                 y_valid, y_data, y_sel, exp_b.data, exp_b.sel);
      end
    end
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_b2b: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
    end
    sb.push_back('{sel: 1'b1, data: 8'h66});
    tick();
    a_valid = 1'b0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL bp_b2b_out: no expected beat queued");
    end else begin
      exp_b = sb.pop_front();
      total++;
      if (y_valid !== 1'b1 || y_data !== exp_b.data || y_sel !== exp_b.sel) begin
        bad++;
        $display("FAIL bp_b2b_out: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                 y_valid, y_data, y_sel, exp_b.data, exp_b.sel);
      end
    end
    tick();
  endtask

  task automatic test_pointer();
    a_valid = 1'b0;
    b_valid = 1'b1;
    b_data  = 8'h22;
    y_ready = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      bad++;
      $display("FAIL ptr_b_only: got a=%b b=%b want a=0 b=1", a_ready, b_ready);
    end
    sb.push_back('{sel: 1'b0, data: 8'h22});
    tick();
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL ptr_b_out: no expected beat queued");
    end else begin
      exp_b = sb.pop_front();
      total++;
      if (y_valid !== 1'b1 || y_data !== exp_b.data || y_sel !== exp_b.sel) begin
        bad++;
        $display("FAIL ptr_b_out: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                 y_valid, y_data, y_sel, exp_b.data, exp_b.sel);
      end
    end
    a_valid = 1'b1;
    a_data  = 8'h33;
    b_data  = 8'h44;
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL ptr_tie: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
    end
    sb.push_back('{sel: 1'b1, data: 8'h33});
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL ptr_a_out: no expected beat queued");
    end else begin
      exp_b = sb.pop_front();
      total++;
      if (y_valid !== 1'b1 || y_data !== exp_b.data || y_sel !== exp_b.sel) begin
        bad++;
        $display("FAIL ptr_a_out: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                 y_valid, y_data, y_sel, exp_b.data, exp_b.sel);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b1;
    a_data  = 8'h99;
    b_valid = 1'b0;
    y_ready = 1'b1;
    #1;
    sb.push_back('{sel: 1'b1, data: 8'h99});
    tick();
    a_valid = 1'b0;
    y_ready = 1'b0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL mid_load: no expected beat queued");
    end else begin
      exp_b = sb.pop_front();
      total++;
      if (y_valid !== 1'b1 || y_data !== exp_b.data || y_sel !== exp_b.sel) begin
        bad++;
        $display("FAIL mid_load: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                 y_valid, y_data, y_sel, exp_b.data, exp_b.sel);
      end
    end
    rst     = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_ready: got a=%b b=%b want a=0 b=0", a_ready, b_ready);
    end
    tick();
    total++;
    if (y_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_drop: got v=%b want v=0", y_valid);
    end
    rst     = 1'b0;
    a_data  = 8'hC1;
    b_data  = 8'hC2;
    y_ready = 1'b1;
    #1;
    // Pointer was at B before reset; reset returns it to A.
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_after: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
    end
    sb.push_back('{sel: 1'b1, data: 8'hC1});
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL mid_after_out: no expected beat queued");
    end else begin
      exp_b = sb.pop_front();
      total++;
      if (y_valid !== 1'b1 || y_data !== exp_b.data || y_sel !== exp_b.sel) begin
        bad++;
        $display("FAIL mid_after_out: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                 y_valid, y_data, y_sel, exp_b.data, exp_b.sel);
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_empty: got %0d leftover beats want 0", sb.size());
    end
  endtask

  initial begin
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = '0;
    b_data  = '0;
    y_ready = 1'b0;
    test_reset();
    test_single();
    test_alternation();
    test_backpressure();
    test_pointer();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux2to1_rr_arbiter.md
# mux2to1_rr_arbiter

- Round-robin arbiter and output-register controller that shares one 2:1 data mux between two valid/ready requesters (`a`, `b`) and one downstream consumer (`y`).
- It decides the mux select each cycle and accepts at most one beat per cycle.
- It holds the selected beat in a single-entry output register until the consumer takes it.
- It sits between two producers and one shared sink; it exists so that no requester can starve the other.

## Interface

Parameters:
- `WIDTH`, default 8: data width of `a_data`, `b_data` and `y_data`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `a_valid`  in  1  requester A has a beat.
- `a_ready`  out  1  A's beat is accepted this cycle.
- `a_data`  in  WIDTH  A's payload.
- `b_valid`  in  1  requester B has a beat.
- `b_ready`  out  1  B's beat is accepted this cycle.
- `b_data`  in  WIDTH  B's payload.
- `y_valid`  out  1  output register holds a beat.
- `y_ready`  in  1  consumer takes the beat this cycle.
- `y_data`  out  WIDTH  registered payload.
- `y_sel`  out  1  source of the current `y_data`: 1 = A, 0 = B. This matches the mux convention `sel ? a : b`.

## Operation

- State:
  - output register: `y_valid`, `y_data`, `y_sel`.
  - priority pointer `prio`: 1 = A preferred, 0 = B preferred.
- Slot free: `free = !y_valid || y_ready`. A full register draining this cycle counts as free, so back-to-back beats are allowed.
- Grant, combinational, only when `free` and not `rst`:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the side named by `prio`.
  - No grant otherwise.
- `a_ready` = grant A; `b_ready` = grant B. Never both in the same cycle. Both are 0 while `rst` = 1.
- The mux select equals the grant: 1 for A, 0 for B.
- On a grant at an edge:
  - `y_data` ← muxed data; `y_sel` ← grant; `y_valid` ← 1.
  - `prio` ← !grant, so the other side is preferred next.
- On `y_ready` with `y_valid` and no new grant: `y_valid` ← 0. `y_data` and `y_sel` hold their last values.
- With `y_valid` = 1 and `y_ready` = 0: `y_data` and `y_sel` are stable, and both input readies are 0.
- `y_ready` while `y_valid` = 0 has no effect.
- Requesters may drop `valid` without a handshake. The arbiter holds no lock on a requester between beats.

## Timing

- Reset values: `y_valid` = 0, `y_data` = 0, `y_sel` = 0, `prio` = 1 (A first).
- A reset asserted while a beat is held discards the beat. `y_valid` = 0 after the reset edge, regardless of `y_ready`.
- Latency: a beat accepted at edge N appears on `y_valid`/`y_data` after edge N, i.e. one cycle.
- Throughput: one beat per cycle while `y_ready` = 1.
- Fairness: with both requesters continuously valid and `y_ready` = 1, grants strictly alternate.
- Ready depends combinationally on `valid` inputs, `y_valid`, `y_ready` and `prio`. Valid never depends on ready.

## Structure

- Package `mux2to1_rr_pkg` holds:
  - `localparam logic SEL_A = 1'b1`, `SEL_B = 1'b0`.
  - the default `WIDTH`.
- The data path instantiates the existing `mux2to1` module once per bit, with `a_data[i]`, `b_data[i]` and the grant as `sel`. Alternatively, a `WIDTH`-parameterised `mux2to1_vec` sub-module wraps those instances.
- Arbiter logic and the output register stay in the top module.

## Test plan

- Reset: hold `rst` = 1 for 2 cycles with both valids high → `a_ready` = `b_ready` = 0, `y_valid` = 0, `y_data` = 0.
- Single source: after reset, `a_valid` = 1, `a_data` = 0x11, `y_ready` = 1 → `a_ready` = 1 that cycle; next cycle `y_valid` = 1, `y_data` = 0x11, `y_sel` = 1.
- Alternation:
  - Stimulus: both valid for 4 cycles; A presents 0xA0–0xA3 and B presents 0xB0–0xB3, each side advancing only on its own ready; `y_ready` = 1.
  - Required: outputs 0xA0, 0xB0, 0xA1, 0xB1 on consecutive cycles, with `y_sel` 1, 0, 1, 0.
- Backpressure:
  - With `y_valid` = 1 and `y_data` = 0x5A, hold `y_ready` = 0 for 3 cycles → both readies 0, `y_data` stays 0x5A.
  - Raise `y_ready` → a new grant happens in the same cycle and the next beat appears one cycle later, with no bubble.
- Pointer after a single grant: B only, 0x22 → accepted. Then both valid → A granted first.
- Reset mid-operation: `y_valid` = 1, `y_ready` = 0, assert `rst` for 1 cycle → `y_valid` = 0. After release, with both valid, A is granted.
